widen_sched: RTL and testbench

Round-robin scheduler that shares one `widen` digit-pulse stretcher between several requesters. Each requester offers a 4-bit decimal digit over a valid/ready handshake. The scheduler grants one requester at a time and drives the stretcher's `data_in`/`enable` for exactly one cycle per accepted digit. It then enforces a guard interval so the 3-cycle stretched pulses from consecutive digits never overlap. It sits between the input sources and the `widen` instance in the encoder datapath.

---
 rtl/widen_sched.sv | 131 +++++++++++++
 tb/tb_widen_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/widen_sched.sv
// widen_sched: round-robin scheduler feeding a single widen digit-pulse stretcher.
// Grants one requester per accept, issues the digit as a one-cycle enable, then
// holds off further accepts so consecutive stretched pulses never overlap.
// Digits above 9 are dropped and reported with a one-cycle error flag.

module widen_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GAP  = 2,
  localparam int unsigned SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_digit,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        w_data,
  output logic              w_enable,
  output logic [SW-1:0]     w_src,
  output logic              err_pulse,
  output logic [SW-1:0]     err_src,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGuard
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   ptr_q;
  logic [3:0]      guard_cnt_q;

  logic            found;
  logic [SW-1:0]   grant_idx;
  logic            grant;
  logic [SW-1:0]   ptr_nxt;
  logic [3:0]      sel_digit;
  logic            sel_bad;

  // Search for the first valid requester at or above the pointer, wrapping around.
  always_comb begin
    int unsigned idx;
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req_valid[idx[SW-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[SW-1:0];
      end
    end
  end

  // Accept decision, one-hot ready strobe and the granted digit.
  always_comb begin
    grant     = (state_q == StIdle) && sched_en && found;
    req_ready = '0;
    if (grant) begin
      req_ready = NREQ'(1) << grant_idx;
    end
    sel_digit = req_digit[{grant_idx, 2'b00} +: 4];
    sel_bad   = (sel_digit > 4'd9);
    // Pointer moves just past the winner so it becomes lowest priority next time.
    if (grant_idx == SW'(NREQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = grant_idx + 1'b1;
    end
  end

  assign busy = (state_q != StIdle);

  // Scheduler FSM with registered stretcher-side and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      guard_cnt_q <= '0;
      w_data      <= '0;
      w_enable    <= 1'b0;
      w_src       <= '0;
      err_pulse   <= 1'b0;
      err_src     <= '0;
    end else begin
      // Both strobes are single-cycle unless re-asserted below.
      w_enable  <= 1'b0;
      err_pulse <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant) begin
            ptr_q <= ptr_nxt;
            if (!sel_bad) begin
              // Data and source are captured at accept so they are valid in ISSUE.
              w_data   <= sel_digit;
              w_src    <= grant_idx;
              w_enable <= 1'b1;
              state_q  <= StIssue;
            end else begin
              // Bad digit: report and stay in IDLE, no guard needed since nothing issued.
              err_pulse <= 1'b1;
              err_src   <= grant_idx;
            end
          end
        end
        StIssue: begin
          if (GAP <= 1) begin
            state_q <= StIdle;
          end else begin
            state_q     <= StGuard;
            guard_cnt_q <= 4'(GAP - 1);
          end
        end
        StGuard: begin
          guard_cnt_q <= guard_cnt_q - 4'd1;
          if (guard_cnt_q <= 4'd1) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_widen_sched.sv
// Directed bench for widen_sched: a 4-requester GAP=2 instance and a
// 2-requester GAP=1 instance, with scoreboards for every issued digit.

module tb_widen_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sched_en;
  logic [3:0]  req_valid;
  logic [15:0] req_digit;
  logic [3:0]  req_ready;
  logic [3:0]  w_data;
  logic        w_enable;
  logic [1:0]  w_src;
  logic        err_pulse;
  logic [1:0]  err_src;
  logic        busy;

  logic        b_en;
  logic [1:0]  b_valid;
  logic [7:0]  b_digit;
  logic [1:0]  b_ready;
  logic [3:0]  b_data;
  logic        b_enable;
  logic [0:0]  b_src;
  logic        b_err;
  logic [0:0]  b_err_src;
  logic        b_busy;

  int tests = 0;
  int fails = 0;

  logic [5:0] exp_a[$];
  logic [4:0] exp_b[$];

  widen_sched #(.NREQ(4), .GAP(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .sched_en  (sched_en),
    .req_valid (req_valid),
    .req_digit (req_digit),
    .req_ready (req_ready),
    .w_data    (w_data),
    .w_enable  (w_enable),
    .w_src     (w_src),
    .err_pulse (err_pulse),
    .err_src   (err_src),
    .busy      (busy)
  );

  widen_sched #(.NREQ(2), .GAP(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .sched_en  (b_en),
    .req_valid (b_valid),
    .req_digit (b_digit),
    .req_ready (b_ready),
    .w_data    (b_data),
    .w_enable  (b_enable),
    .w_src     (b_src),
    .err_pulse (b_err),
    .err_src   (b_err_src),
    .busy      (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for instance A: every enable must match the next expected {src, digit}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w_enable === 1'b1) begin
      if (exp_a.size() == 0) begin
        chk("a_sb_entry_available", 32'(exp_a.size()), 32'd1);
      end else begin
        chk("a_issue", {26'd0, w_src, w_data}, {26'd0, exp_a.pop_front()});
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && b_enable === 1'b1) begin
      if (exp_b.size() == 0) begin
        chk("b_sb_entry_available", 32'(exp_b.size()), 32'd1);
      end else begin
        chk("b_issue", {27'd0, b_src, b_data}, {27'd0, exp_b.pop_front()});
      end
    end
  end

  initial begin
    logic [3:0] e4;
    logic [1:0] e2;

    rst_n     = 1'b0;
    sched_en  = 1'b1;
    req_valid = '0;
    req_digit = '0;
    b_en      = 1'b1;
    b_valid   = '0;
    b_digit   = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_w_data", w_data, 0);
    chk("rst_w_enable", w_enable, 0);
    chk("rst_w_src", w_src, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_src", err_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, digit 7 from requester 0.
    @(negedge clk);
    req_valid = 4'b0001;
    req_digit = 16'h0007;
    exp_a.push_back({2'd0, 4'd7});
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_busy_idle", busy, 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t1_enable", w_enable, 1);
    chk("t1_data", w_data, 7);
    chk("t1_src", w_src, 0);
    chk("t1_busy_issue", busy, 1);
    chk("t1_ready_off", req_ready, 0);
    @(negedge clk);
    #1;
    chk("t1_busy_guard", busy, 1);
    chk("t1_enable_off", w_enable, 0);
    chk("t1_data_hold", w_data, 7);
    @(negedge clk);
    #1;
    chk("t1_busy_done", busy, 0);

    // Pointer is now 1; a reset must bring it back to 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness: all valid, digits 1..4, accepts every 3 cycles.
    @(negedge clk);
    req_valid = 4'hF;
    req_digit = 16'h4321;
    for (int g = 0; g < 8; g++) begin
      e2 = 2'(g % 4);
      exp_a.push_back({e2, 4'(g % 4 + 1)});
    end
    for (int k = 0; k < 24; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      e4 = (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'd0;
      chk("t2_ready", req_ready, e4);
    end
    @(negedge clk);
    req_valid = '0;

    // Invalid digit from requester 2, requester 3 waiting with 5.
    @(negedge clk);
    req_valid = 4'b1100;
    req_digit = 16'h5C00;
    #1;
    chk("t3_ready_bad", req_ready, 4'b0100);
    @(negedge clk);
    exp_a.push_back({2'd3, 4'd5});
    #1;
    chk("t3_err_pulse", err_pulse, 1);
    chk("t3_err_src", err_src, 2);
    chk("t3_no_enable", w_enable, 0);
    chk("t3_busy", busy, 0);
    chk("t3_ready_next", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t3_enable", w_enable, 1);
    chk("t3_data", w_data, 5);
    chk("t3_src", w_src, 3);
    chk("t3_err_clear", err_pulse, 0);
    chk("t3_err_src_hold", err_src, 2);

    // sched_en gating for 10 cycles, then grant to requester at ptr (0).
    @(negedge clk);
    sched_en  = 1'b0;
    req_valid = 4'b0111;
    req_digit = 16'h0986;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk("t4_gated", req_ready, 0);
    end
    @(negedge clk);
    sched_en = 1'b1;
    exp_a.push_back({2'd0, 4'd6});
    #1;
    chk("t4_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t4_enable", w_enable, 1);
    chk("t4_data", w_data, 6);

    // Reset during GUARD.
    @(negedge clk);
    #1;
    chk("t5_in_guard", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_w_data", w_data, 0);
    chk("t5_w_src", w_src, 0);
    chk("t5_w_enable", w_enable, 0);
    chk("t5_err_src", err_src, 0);
    chk("t5_err_pulse", err_pulse, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    req_digit = 16'h0030;
    exp_a.push_back({2'd1, 4'd3});
    #1;
    chk("t5_ready_after", req_ready, 4'b0010);
    chk("t5_no_stale_enable", w_enable, 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5_enable", w_enable, 1);
    chk("t5_data", w_data, 3);
    chk("t5_src", w_src, 1);

    // GAP=1 instance: two requesters continuously valid, enable every 2 cycles.
    @(negedge clk);
    b_valid = 2'b11;
    b_digit = 8'h94;
    exp_b.push_back({1'b0, 4'd4});
    exp_b.push_back({1'b1, 4'd9});
    exp_b.push_back({1'b0, 4'd4});
    exp_b.push_back({1'b1, 4'd9});
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      e2 = (k % 2 == 0) ? 2'(1 << ((k / 2) % 2)) : 2'd0;
      chk("t6_ready", b_ready, e2);
      chk("t6_enable", b_enable, (k % 2 == 1) ? 1 : 0);
      chk("t6_busy", b_busy, (k % 2 == 1) ? 1 : 0);
    end
    @(negedge clk);
    b_valid = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("a_sb_drained", 32'(exp_a.size()), 0);
    chk("b_sb_drained", 32'(exp_b.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
